// File: rtl/mem_bus_arb_if.sv
// mem_bus_arb_if: requester ports and shared memory bus seen by the arbiter
interface mem_bus_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [3:0]            d_op_i;
    logic                  d_done_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  i_req_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic                  i_done_o;
    logic [DATA_WIDTH-1:0] i_rdata_o;
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_WIDTH-1:0] bus_addr_o;
    logic [DATA_WIDTH-1:0] bus_wdata_o;
    logic [3:0]            bus_op_o;
    logic                  bus_ack_i;
    logic [DATA_WIDTH-1:0] bus_rdata_i;
    logic                  err_o;
    logic                  mem_stall_o;
    logic                  if_stall_o;

    modport master (
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_op_i, i_req_i, i_addr_i,
        input  bus_ack_i, bus_rdata_i,
        output d_done_o, d_rdata_o, i_done_o, i_rdata_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_op_o,
        output err_o, mem_stall_o, if_stall_o
    );

    modport slave (
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_op_i, i_req_i, i_addr_i,
        output bus_ack_i, bus_rdata_i,
        input  d_done_o, d_rdata_o, i_done_o, i_rdata_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_op_o,
        input  err_o, mem_stall_o, if_stall_o
    );
endinterface

// File: rtl/mem_bus_arb.sv
// mem_bus_arb: data/fetch arbiter for one shared memory bus with timeout and anti-starvation
module mem_bus_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 15
) (
    input logic clk_i,
    input logic rst_i,
    mem_bus_arb_if.master m
);
    localparam logic [3:0] MEM_NOP  = 4'h0;
    localparam logic [3:0] MEM_WORD = 4'h3;
    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] consec;
    logic [TW-1:0] tcnt;
    logic          free, gnt_d, gnt_i, tmo, fin;

    assign m.mem_stall_o = m.d_req_i & ~m.d_done_o;
    assign m.if_stall_o  = m.i_req_i & ~m.i_done_o;

    always_ff @(posedge clk_i)
        state <= rst_i ? IDLE : state_nx;

    // The done cycle is dead: requesters still show the finished request there.
    always_comb begin
        free     = state == IDLE && !m.d_done_o && !m.i_done_o;
        gnt_i    = free && m.i_req_i && (!m.d_req_i || consec == CW'(MAX_CONSEC));
        gnt_d    = free && m.d_req_i && !gnt_i;
        tmo      = state != IDLE && !m.bus_ack_i && tcnt == TW'(TIMEOUT - 1);
        fin      = state != IDLE && (m.bus_ack_i || tmo);
        state_nx = fin ? IDLE : gnt_d ? BUSY_D : gnt_i ? BUSY_I : state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m.d_done_o    <= 1'b0;
            m.i_done_o    <= 1'b0;
            m.err_o       <= 1'b0;
            m.d_rdata_o   <= '0;
            m.i_rdata_o   <= '0;
            m.bus_req_o   <= 1'b0;
            m.bus_we_o    <= 1'b0;
            m.bus_addr_o  <= '0;
            m.bus_wdata_o <= '0;
            m.bus_op_o    <= MEM_NOP;
            consec        <= '0;
            tcnt          <= '0;
        end else begin
            m.d_done_o <= fin && state == BUSY_D;
            m.i_done_o <= fin && state == BUSY_I;
            m.err_o    <= tmo;
            if (fin && state == BUSY_D)
                m.d_rdata_o <= (tmo || m.bus_we_o) ? '0 : m.bus_rdata_i;
            if (fin && state == BUSY_I)
                m.i_rdata_o <= tmo ? '0 : m.bus_rdata_i;
            tcnt <= (state == IDLE || fin) ? '0 : tcnt + TW'(1);
            if (gnt_d) begin
                m.bus_req_o   <= 1'b1;
                m.bus_we_o    <= m.d_we_i;
                m.bus_addr_o  <= m.d_addr_i;
                m.bus_wdata_o <= m.d_wdata_i;
                m.bus_op_o    <= m.d_op_i;
                consec        <= !m.i_req_i ? '0 : consec == CW'(MAX_CONSEC) ? consec : consec + CW'(1);
            end else if (gnt_i) begin
                m.bus_req_o   <= 1'b1;
                m.bus_we_o    <= 1'b0;
                m.bus_addr_o  <= m.i_addr_i;
                m.bus_wdata_o <= '0;
                m.bus_op_o    <= MEM_WORD;
                consec        <= '0;
            end else if (fin) begin
                m.bus_req_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb: directed and randomized checks of mem_bus_arb against a transaction-level model
module tb_mem_bus_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAXC = 4;
    localparam int TMO = 15;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_WORD = 4'h3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif();

    mem_bus_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CONSEC(MAXC), .TIMEOUT(TMO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .m(bif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit            d_pend, i_pend, d_we;
    logic [AW-1:0] d_addr, i_addr;
    logic [DW-1:0] d_wdata, last_d, last_i;
    logic [3:0]    d_op;
    int            streak;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [3:0] op);
        d_pend = 1; d_we = we; d_addr = a; d_wdata = wd; d_op = op;
        bif.d_req_i = 1'b1; bif.d_we_i = we; bif.d_addr_i = a; bif.d_wdata_i = wd; bif.d_op_i = op;
    endtask

    task automatic set_i(input logic [AW-1:0] a);
        i_pend = 1; i_addr = a;
        bif.i_req_i = 1'b1; bif.i_addr_i = a;
    endtask

    // wait_n < 0: slave never acks; otherwise ack after wait_n idle bus cycles
    task automatic txn(input int wait_n, input logic [DW-1:0] rd, input int lat, output bit got_d);
        bit            exp_d;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_rd;
        logic [3:0]    e_op;
        int            w, c;
        exp_d = d_pend && !(i_pend && streak == MAXC);
        if (exp_d) begin
            e_we = d_we; e_addr = d_addr; e_wd = d_wdata; e_op = d_op;
            streak = i_pend ? (streak == MAXC ? MAXC : streak + 1) : 0;
        end else begin
            e_we = 1'b0; e_addr = i_addr; e_wd = '0; e_op = OP_WORD;
            streak = 0;
        end
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bif.bus_req_o && w < 10);
        chk("grant_latency", 128'(w), 128'(lat));
        c = 0;
        while (bif.bus_req_o && c < 40) begin
            chk("bus_fields", {bif.bus_we_o, bif.bus_addr_o, bif.bus_wdata_o, bif.bus_op_o},
                {e_we, e_addr, e_wd, e_op});
            chk("stall_busy", {bif.mem_stall_o, bif.if_stall_o, bif.d_done_o, bif.i_done_o, bif.err_o},
                {d_pend, i_pend, 3'b000});
            if (c == wait_n) begin
                bif.bus_ack_i = 1'b1;
                bif.bus_rdata_i = rd;
            end
            @(negedge clk);
            bif.bus_ack_i = 1'b0;
            bif.bus_rdata_i = $urandom;
            c++;
        end
        chk("req_cycles", 128'(c), 128'(wait_n < 0 ? TMO : wait_n + 1));
        e_rd = (wait_n < 0 || (exp_d && e_we)) ? '0 : rd;
        if (exp_d) last_d = e_rd; else last_i = e_rd;
        got_d = bif.d_done_o;
        chk("done_err", {bif.d_done_o, bif.i_done_o, bif.err_o}, {exp_d, !exp_d, wait_n < 0});
        chk("d_rdata", bif.d_rdata_o, last_d);
        chk("i_rdata", bif.i_rdata_o, last_i);
        chk("stall_done", {bif.mem_stall_o, bif.if_stall_o},
            {exp_d ? 1'b0 : d_pend, exp_d ? i_pend : 1'b0});
        if (exp_d) begin d_pend = 0; bif.d_req_i = 1'b0; end
        else begin i_pend = 0; bif.i_req_i = 1'b0; end
    endtask

    initial begin
        bit       gd;
        bit [5:0] order;
        int       w;
        bif.d_req_i = 0; bif.d_we_i = 0; bif.d_addr_i = '0; bif.d_wdata_i = '0; bif.d_op_i = OP_NOP;
        bif.i_req_i = 0; bif.i_addr_i = '0; bif.bus_ack_i = 0; bif.bus_rdata_i = '0;
        d_pend = 0; i_pend = 0; streak = 0; last_d = '0; last_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bif.bus_req_o, bif.bus_we_o, bif.bus_addr_o, bif.bus_wdata_o, bif.bus_op_o},
            {1'b0, 1'b0, 32'h0, 32'h0, OP_NOP});
        chk("reset_flags", {bif.d_done_o, bif.i_done_o, bif.err_o, bif.mem_stall_o, bif.if_stall_o, bif.d_rdata_o, bif.i_rdata_o},
            '0);
        rst = 1'b0;

        // single data read, ack one cycle into the bus request
        set_d(0, 32'h100, '0, OP_WORD);
        txn(1, 32'hDEADBEEF, 1, gd);

        // simultaneous requests: store wins, then fetch
        set_d(1, 32'h200, 32'h55, OP_WORD);
        set_i(32'h0);
        txn(0, 32'h1111_2222, 2, gd);
        txn(0, 32'h0000_0013, 2, gd);

        // starvation guard with both requesters permanently busy
        set_d(0, 32'h300, '0, 4'h1);
        set_i(32'h4);
        order = '0;
        for (int k = 0; k < 6; k++) begin
            txn(0, $urandom, 2, gd);
            order = {order[4:0], gd};
            if (!d_pend) set_d(0, 32'h300 + 32'(k), '0, 4'(1 + k % 3));
            if (!i_pend) set_i(32'h8 + 32'(4 * k));
        end
        chk("starve_order", 128'(order), 128'(6'b111101));
        for (int k = 0; k < 3 && (d_pend || i_pend); k++) txn(0, $urandom, 2, gd);

        // timeout on a data read, then a late ack in idle must be ignored
        set_d(0, 32'h500, '0, OP_WORD);
        txn(-1, 32'hBAD0BAD0, 2, gd);
        bif.bus_ack_i = 1'b1;
        @(negedge clk);
        bif.bus_ack_i = 1'b0;
        chk("late_ack_ignored", {bif.bus_req_o, bif.d_done_o, bif.i_done_o, bif.err_o}, '0);
        set_i(32'h40);
        txn(0, 32'hCAFE_F00D, 1, gd);

        // reset in the middle of a fetch
        set_i(32'h80);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bif.bus_req_o && w < 10);
        chk("mid_rst_grant", bif.bus_req_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_drop", {bif.bus_req_o, bif.i_done_o, bif.d_done_o, bif.err_o, bif.if_stall_o}, 5'b00001);
        streak = 0; last_d = '0; last_i = '0;
        txn(0, 32'h1234_5678, 1, gd);

        // back-to-back stores with three wait states
        set_d(1, 32'h400, $urandom, 4'h2);
        txn(3, $urandom, 2, gd);
        set_d(1, 32'h404, $urandom, OP_WORD);
        txn(3, $urandom, 2, gd);

        // random traffic
        for (int k = 0; k < 60; k++) begin
            if (!d_pend && $urandom_range(0, 3) != 0)
                set_d(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 3)));
            if (!i_pend && $urandom_range(0, 2) != 0)
                set_i($urandom);
            if (!d_pend && !i_pend) set_i($urandom);
            txn($urandom_range(0, 19) == 0 ? -1 : int'($urandom_range(0, 4)), $urandom, 2, gd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
